// File: rtl/dummy_unit_stub_slave.sv
// Terminates NUM_CH master interfaces with a per-channel scratch-register slave.
// Each channel has programmable response latency and flags illegal accesses.
`timescale 1ns/1ps
module dummy_unit_stub_slave #(
  parameter int NUM_CH  = 3,
  parameter int AW      = 4,
  parameter int DW      = 8,
  parameter int DEPTH   = 16,
  parameter int LATENCY = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NUM_CH*AW-1:0] dummy_master_ifc_address,
  input  logic [NUM_CH*DW-1:0] dummy_master_ifc_write_data,
  input  logic [NUM_CH-1:0]    dummy_master_ifc_read,
  input  logic [NUM_CH-1:0]    dummy_master_ifc_write,
  output logic [NUM_CH*DW-1:0] dummy_master_ifc_read_data,
  output logic [NUM_CH-1:0]    dummy_master_ifc_ready,
  output logic [NUM_CH-1:0]    dummy_master_ifc_error,
  output logic [NUM_CH*2-1:0]  dbg_state
);

  // Handshake: a request (read|write) is sampled only in IDLE. The master holds it
  // until it sees the one-cycle ready pulse; ready is visible in the cycle after the
  // FSM leaves RESP, so a request still high at the end of that cycle starts a new one.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_e;

  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);
  localparam logic [3:0]  LAT_W   = 4'(LATENCY);

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    state_e          state_q;
    logic [3:0]      cnt_q;
    logic [AW-1:0]   addr_q;
    logic [DW-1:0]   wdata_q;
    logic            rd_q;
    logic            wr_q;
    logic            ready_q;
    logic            error_q;
    logic [DW-1:0]   rdata_q;
    logic [DW-1:0]   mem_q [2**AW];
    logic            bad;

    // Entries at or above DEPTH are never written, so they stay constant zero.
    assign bad = ({1'b0, addr_q} >= DEPTH_W) || (rd_q && wr_q);

    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        state_q <= S_IDLE;
        cnt_q   <= '0;
        addr_q  <= '0;
        wdata_q <= '0;
        rd_q    <= 1'b0;
        wr_q    <= 1'b0;
        ready_q <= 1'b0;
        error_q <= 1'b0;
        rdata_q <= '0;
        for (int i = 0; i < 2**AW; i++) mem_q[i] <= '0;
      end else begin
        ready_q <= 1'b0;
        error_q <= 1'b0;
        rdata_q <= '0;
        case (state_q)
          S_IDLE: begin
            if (dummy_master_ifc_read[c] || dummy_master_ifc_write[c]) begin
              addr_q  <= dummy_master_ifc_address[c*AW +: AW];
              wdata_q <= dummy_master_ifc_write_data[c*DW +: DW];
              rd_q    <= dummy_master_ifc_read[c];
              wr_q    <= dummy_master_ifc_write[c];
              cnt_q   <= LAT_W;
              state_q <= (LATENCY > 0) ? S_WAIT : S_RESP;
            end
          end
          S_WAIT: begin
            cnt_q <= cnt_q - 4'd1;
            if (cnt_q == 4'd1) state_q <= S_RESP;
          end
          S_RESP: begin
            ready_q <= 1'b1;
            error_q <= bad;
            if (!bad) begin
              if (wr_q) mem_q[addr_q] <= wdata_q;
              else      rdata_q       <= mem_q[addr_q];
            end
            state_q <= S_IDLE;
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end

    assign dummy_master_ifc_ready[c]              = ready_q;
    assign dummy_master_ifc_error[c]              = error_q;
    assign dummy_master_ifc_read_data[c*DW +: DW] = rdata_q;
    assign dbg_state[c*2 +: 2]                    = state_q;
  end

endmodule

// File: tb/tb_dummy_unit_stub_slave.sv
// Directed bench for dummy_unit_stub_slave: one instance with LATENCY=2/DEPTH=12
// and one with LATENCY=0 for back-to-back held-request checks.
`timescale 1ns/1ps
module tb_dummy_unit_stub_slave;

  localparam int NC = 3;
  localparam int AW = 4;
  localparam int DW = 8;

  logic clock = 1'b0;
  logic reset = 1'b1;

  // Instance A: LATENCY=2, DEPTH=12
  logic [NC*AW-1:0] a_addr  = '0;
  logic [NC*DW-1:0] a_wdata = '0;
  logic [NC-1:0]    a_rd    = '0;
  logic [NC-1:0]    a_wr    = '0;
  logic [NC*DW-1:0] a_rdata;
  logic [NC-1:0]    a_ready;
  logic [NC-1:0]    a_error;
  logic [NC*2-1:0]  a_state;

  // Instance B: LATENCY=0, DEPTH=16
  logic [NC*AW-1:0] b_addr  = '0;
  logic [NC*DW-1:0] b_wdata = '0;
  logic [NC-1:0]    b_rd    = '0;
  logic [NC-1:0]    b_wr    = '0;
  logic [NC*DW-1:0] b_rdata;
  logic [NC-1:0]    b_ready;
  logic [NC-1:0]    b_error;
  logic [NC*2-1:0]  b_state;

  int n_assert = 0;
  int n_fail   = 0;

  dummy_unit_stub_slave #(.NUM_CH(NC), .AW(AW), .DW(DW), .DEPTH(12), .LATENCY(2)) u_dut_a (
    .clock                       (clock),
    .reset                       (reset),
    .dummy_master_ifc_address    (a_addr),
    .dummy_master_ifc_write_data (a_wdata),
    .dummy_master_ifc_read       (a_rd),
    .dummy_master_ifc_write      (a_wr),
    .dummy_master_ifc_read_data  (a_rdata),
    .dummy_master_ifc_ready      (a_ready),
    .dummy_master_ifc_error      (a_error),
    .dbg_state                   (a_state)
  );

  dummy_unit_stub_slave #(.NUM_CH(NC), .AW(AW), .DW(DW), .DEPTH(16), .LATENCY(0)) u_dut_b (
    .clock                       (clock),
    .reset                       (reset),
    .dummy_master_ifc_address    (b_addr),
    .dummy_master_ifc_write_data (b_wdata),
    .dummy_master_ifc_read       (b_rd),
    .dummy_master_ifc_write      (b_wr),
    .dummy_master_ifc_read_data  (b_rdata),
    .dummy_master_ifc_ready      (b_ready),
    .dummy_master_ifc_error      (b_error),
    .dbg_state                   (b_state)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One complete transaction on instance A (sel=0) or B (sel=1); called at a negedge.
  task automatic txn(input bit sel, input int ch, input bit rd, input bit wr,
                     input logic [3:0] addr, input logic [7:0] data,
                     input logic [7:0] exp_rdata, input bit exp_err, input string tag);
    int cyc;
    logic [NC-1:0] rdy;
    if (!sel) begin
      a_addr[ch*AW +: AW] = addr; a_wdata[ch*DW +: DW] = data;
      a_rd[ch] = rd; a_wr[ch] = wr;
    end else begin
      b_addr[ch*AW +: AW] = addr; b_wdata[ch*DW +: DW] = data;
      b_rd[ch] = rd; b_wr[ch] = wr;
    end
    cyc = 0;
    do begin
      @(negedge clock);
      cyc++;
      rdy = sel ? b_ready : a_ready;
    end while (!rdy[ch] && cyc < 20);
    check({tag, " latency"}, cyc, sel ? 2 : 4);
    check({tag, " ready"}, rdy[ch], 1);
    check({tag, " error"}, sel ? b_error[ch] : a_error[ch], exp_err);
    check({tag, " rdata"}, sel ? b_rdata[ch*DW +: DW] : a_rdata[ch*DW +: DW], exp_rdata);
    if (!sel) begin a_rd[ch] = 1'b0; a_wr[ch] = 1'b0; end
    else      begin b_rd[ch] = 1'b0; b_wr[ch] = 1'b0; end
    @(negedge clock);
    rdy = sel ? b_ready : a_ready;
    check({tag, " ready width"}, rdy[ch], 0);
  endtask

  initial begin
    int cyc;
    int pulses;

    // Reset state
    repeat (3) @(negedge clock);
    check("rst ready", a_ready, 0);
    check("rst error", a_error, 0);
    check("rst rdata", a_rdata, 0);
    check("rst state", a_state, 0);
    reset = 1'b0;
    @(negedge clock);

    // Put a known value at ch1 addr 3 so the reset clear is observable
    txn(0, 1, 0, 1, 4'd3, 8'h5A, 8'h00, 0, "t1 pre wr");
    txn(0, 1, 1, 0, 4'd3, 8'h00, 8'h5A, 0, "t1 pre rd");

    // T1: reset during WAIT on ch1 aborts the write
    a_addr[1*AW +: AW] = 4'd3; a_wdata[1*DW +: DW] = 8'h77; a_wr[1] = 1'b1;
    repeat (2) @(negedge clock);
    check("t1 in wait", a_state[3:2], 2'd1);
    reset = 1'b1;
    #1;
    check("t1 rst ready", a_ready, 0);
    check("t1 rst rdata", a_rdata, 0);
    check("t1 rst state", a_state, 0);
    a_wr[1] = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      if (a_ready != 0) pulses++;
    end
    check("t1 no ready", pulses, 0);
    txn(0, 1, 1, 0, 4'd3, 8'h00, 8'h00, 0, "t1 rd");

    // T2: write then read on ch0
    txn(0, 0, 0, 1, 4'd5, 8'hA5, 8'h00, 0, "t2 wr");
    txn(0, 0, 1, 0, 4'd5, 8'h00, 8'hA5, 0, "t2 rd");

    // T3: out-of-range on ch2 (DEPTH=12)
    txn(0, 2, 0, 1, 4'd13, 8'hFF, 8'h00, 1, "t3 wr13");
    txn(0, 2, 1, 0, 4'd13, 8'h00, 8'h00, 1, "t3 rd13");
    txn(0, 2, 0, 1, 4'd12, 8'h44, 8'h00, 1, "t3 wr12");
    txn(0, 2, 1, 0, 4'd11, 8'h00, 8'h00, 0, "t3 rd11");
    txn(0, 2, 0, 1, 4'd11, 8'h3C, 8'h00, 0, "t3 wr11");
    txn(0, 2, 1, 0, 4'd11, 8'h00, 8'h3C, 0, "t3 rd11b");

    // T4: read and write together is an error and leaves memory alone
    txn(0, 1, 1, 1, 4'd2, 8'h99, 8'h00, 1, "t4 rdwr");
    txn(0, 1, 1, 0, 4'd2, 8'h00, 8'h00, 0, "t4 rd");

    // T5: simultaneous writes to addr 0 on all channels
    a_addr  = '0;
    a_wdata = {8'h33, 8'h22, 8'h11};
    a_wr    = 3'b111;
    cyc = 0;
    do begin
      @(negedge clock);
      cyc++;
    end while (a_ready == 0 && cyc < 20);
    check("t5 latency", cyc, 4);
    check("t5 ready", a_ready, 3'b111);
    check("t5 error", a_error, 0);
    a_wr = '0;
    @(negedge clock);
    txn(0, 0, 1, 0, 4'd0, 8'h00, 8'h11, 0, "t5 rd0");
    txn(0, 1, 1, 0, 4'd0, 8'h00, 8'h22, 0, "t5 rd1");
    txn(0, 2, 1, 0, 4'd0, 8'h00, 8'h33, 0, "t5 rd2");

    // T6: LATENCY=0, held read on ch1 of instance B
    txn(1, 1, 0, 1, 4'd4, 8'h5C, 8'h00, 0, "t6 wr");
    b_addr[1*AW +: AW] = 4'd4;
    b_rd[1] = 1'b1;
    pulses = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clock);
      check($sformatf("t6 ready c%0d", k), b_ready[1], (k % 2 == 0) ? 1 : 0);
      check($sformatf("t6 rdata c%0d", k), b_rdata[1*DW +: DW], (k % 2 == 0) ? 8'h5C : 8'h00);
      if (b_ready[1]) pulses++;
    end
    check("t6 pulses", pulses, 6);
    b_rd[1] = 1'b0;
    repeat (2) @(negedge clock);
    check("t6 idle ready", b_ready, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
